// File: rtl/ad_array_pipe.sv
// ad_array_pipe: absolute-difference systolic array for block motion estimation.
// Reference pixels shift right-to-left along each row, partial SADs flow
// top-to-bottom, and one PSAD vector per column/lane leaves the bottom row
// on every step once the array is filled.
// Build option: define AD_ARRAY_SAT_EN to make every PE adder saturate at
// 2^PSAD_BIT_WIDTH-1 instead of wrapping.
// EDGE_ROWS and EDGE_COLS must both be at least 2.

// One processing element: |ref - cur| per lane, added to the PSAD from above.
module ad_array_pe #(
   parameter int LANES = 16,
   parameter int BD    = 8,
   parameter int PSW   = 11
) (
   input  logic [LANES*BD-1:0]  i_ref,
   input  logic [BD-1:0]        i_cur,
   input  logic [LANES*PSW-1:0] i_psad,
   output logic [LANES*PSW-1:0] o_sum
);
   localparam int SW = PSW + 1;

   for (genvar p = 0; p < LANES; p++) begin : g_lane
      logic [BD-1:0] w_ref;
      logic [BD-1:0] w_ad;

      assign w_ref = i_ref[p*BD +: BD];
      assign w_ad  = (w_ref >= i_cur) ? (w_ref - i_cur) : (i_cur - w_ref);
`ifdef AD_ARRAY_SAT_EN
      // one guard bit catches overflow, which clamps to all ones
      logic [SW-1:0] w_full;
      assign w_full = SW'(w_ad) + {1'b0, i_psad[p*PSW +: PSW]};
      assign o_sum[p*PSW +: PSW] = w_full[PSW] ? {PSW{1'b1}} : w_full[PSW-1:0];
`else
      // plain modulo-2^PSW accumulation
      assign o_sum[p*PSW +: PSW] = PSW'(w_ad) + i_psad[p*PSW +: PSW];
`endif
   end
endmodule

module ad_array_pipe #(
   parameter int PIXELS_IN_BATCH = 16,
   parameter int EDGE_ROWS       = 8,
   parameter int EDGE_COLS       = 8,
   parameter int BIT_DEPTH       = 8,
   parameter int PSAD_BIT_WIDTH  = 11
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                ref_valid_in,
   output logic                                                ref_ready_out,
   input  logic [EDGE_ROWS*PIXELS_IN_BATCH*BIT_DEPTH-1:0]      reference_input_column,
   input  logic                                                cur_load,
   input  logic [EDGE_ROWS*EDGE_COLS*BIT_DEPTH-1:0]            current_input_complete,
   output logic                                                psad_valid_out,
   output logic [PSAD_BIT_WIDTH*EDGE_COLS*PIXELS_IN_BATCH-1:0] psad_addend_batch
);
   localparam int LW   = PIXELS_IN_BATCH * BIT_DEPTH;       // one row word of ref pixels
   localparam int PW   = PIXELS_IN_BATCH * PSAD_BIT_WIDTH;  // one column word of PSADs
   localparam int FILL = EDGE_ROWS + EDGE_COLS - 2;
   localparam int CW   = $clog2(FILL + 1);
   localparam logic [CW-1:0] FILL_C = CW'(FILL);

   logic [EDGE_ROWS*EDGE_COLS*BIT_DEPTH-1:0]          r_cur;
   logic [EDGE_ROWS-1:0][EDGE_COLS-2:0][LW-1:0]       r_ref;
   logic [EDGE_ROWS-2:0][EDGE_COLS-1:0][PW-1:0]       r_psad;
   logic [EDGE_COLS-1:0][PW-1:0]                      r_out;
   logic [CW-1:0]                                     r_fill;
   logic                                              r_valid;

   logic [EDGE_ROWS-1:0][EDGE_COLS-1:0][LW-1:0]       w_ref;
   logic [EDGE_ROWS-1:0][EDGE_COLS-1:0][PW-1:0]       w_pin;
   logic [EDGE_ROWS-1:0][EDGE_COLS-1:0][PW-1:0]       w_sum;
   logic                                              w_step;

   // a load cycle owns the array, so any beat presented with it is refused
   assign ref_ready_out = ~cur_load;
   assign w_step        = ref_valid_in & ~cur_load;

   for (genvar i = 0; i < EDGE_ROWS; i++) begin : g_row
      // row input lands directly on the rightmost PE; the rest come from the shift regs
      assign w_ref[i][EDGE_COLS-1]   = reference_input_column[i*LW +: LW];
      assign w_ref[i][EDGE_COLS-2:0] = r_ref[i];

      if (i == 0) begin : g_top
         assign w_pin[i] = '0;
      end else begin : g_mid
         assign w_pin[i] = r_psad[i-1];
      end

      for (genvar j = 0; j < EDGE_COLS; j++) begin : g_col
         ad_array_pe #(
            .LANES (PIXELS_IN_BATCH),
            .BD    (BIT_DEPTH),
            .PSW   (PSAD_BIT_WIDTH)
         ) u_pe (
            .i_ref  (w_ref[i][j]),
            .i_cur  (r_cur[(i*EDGE_COLS+j)*BIT_DEPTH +: BIT_DEPTH]),
            .i_psad (w_pin[i][j]),
            .o_sum  (w_sum[i][j])
         );
      end
   end

   // current-block register: captured only on a load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_cur <= '0;
      else if (cur_load) r_cur <= current_input_complete;
   end

   // reference shift and PSAD pipeline: cleared by a load, advanced on steps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ref  <= '0;
         r_psad <= '0;
      end else if (cur_load) begin
         r_ref  <= '0;
         r_psad <= '0;
      end else if (w_step) begin
         for (int i = 0; i < EDGE_ROWS; i++)
            r_ref[i] <= w_ref[i][EDGE_COLS-1:1];
         r_psad <= w_sum[EDGE_ROWS-2:0];
      end
   end

   // output register keeps its last vector across loads and idle cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    r_out <= '0;
      else if (w_step)             r_out <= w_sum[EDGE_ROWS-1];
   end

   // fill counter saturates at FILL; a step taken while full yields a valid vector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fill  <= '0;
         r_valid <= 1'b0;
      end else if (cur_load) begin
         r_fill  <= '0;
         r_valid <= 1'b0;
      end else if (w_step) begin
         r_valid <= (r_fill == FILL_C);
         if (r_fill != FILL_C) r_fill <= r_fill + 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign psad_valid_out    = r_valid;
   assign psad_addend_batch = r_out;
endmodule

// File: tb/tb_ad_array_pipe.sv
// Bench for ad_array_pipe: default 8x8 array, a 4x4 array for skew/stall
// checks, and a 9-bit-PSAD array for the saturation/wrap check.
module tb_ad_array_pipe;
   localparam int P  = 16, R  = 8, C  = 8, BD = 8, PW = 11;
   localparam int SP = 2,  SR = 4, SC = 4;
   localparam int TP = 1,  TW = 9;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // default array
   logic                d_vld, d_load, d_rdy, d_ov;
   logic [R*P*BD-1:0]   d_ref;
   logic [R*C*BD-1:0]   d_cur;
   logic [PW*C*P-1:0]   d_out, exp_d;
   // 4x4 skew array
   logic                s_vld, s_load, s_rdy, s_ov;
   logic [SR*SP*BD-1:0] s_ref;
   logic [SR*SC*BD-1:0] s_cur;
   logic [PW*SC*SP-1:0] s_out, exp_s;
   // narrow-PSAD array
   logic                t_vld, t_load, t_rdy, t_ov;
   logic [R*TP*BD-1:0]  t_ref;
   logic [R*C*BD-1:0]   t_cur;
   logic [TW*C*TP-1:0]  t_out, exp_t;

   int errs   = 0;
   int checks = 0;

   ad_array_pipe #(.PIXELS_IN_BATCH(P), .EDGE_ROWS(R), .EDGE_COLS(C),
                   .BIT_DEPTH(BD), .PSAD_BIT_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .ref_valid_in(d_vld), .ref_ready_out(d_rdy),
      .reference_input_column(d_ref), .cur_load(d_load),
      .current_input_complete(d_cur), .psad_valid_out(d_ov),
      .psad_addend_batch(d_out));

   ad_array_pipe #(.PIXELS_IN_BATCH(SP), .EDGE_ROWS(SR), .EDGE_COLS(SC),
                   .BIT_DEPTH(BD), .PSAD_BIT_WIDTH(PW)) dut_s (
      .clk(clk), .rst(rst), .ref_valid_in(s_vld), .ref_ready_out(s_rdy),
      .reference_input_column(s_ref), .cur_load(s_load),
      .current_input_complete(s_cur), .psad_valid_out(s_ov),
      .psad_addend_batch(s_out));

   ad_array_pipe #(.PIXELS_IN_BATCH(TP), .EDGE_ROWS(R), .EDGE_COLS(C),
                   .BIT_DEPTH(BD), .PSAD_BIT_WIDTH(TW)) dut_t (
      .clk(clk), .rst(rst), .ref_valid_in(t_vld), .ref_ready_out(t_rdy),
      .reference_input_column(t_ref), .cur_load(t_load),
      .current_input_complete(t_cur), .psad_valid_out(t_ov),
      .psad_addend_batch(t_out));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d_ref(input logic [7:0] v);
      for (int k = 0; k < R*P; k++) d_ref[k*BD +: BD] = v;
   endtask

   task automatic set_d_exp(input logic [PW-1:0] v);
      for (int k = 0; k < C*P; k++) exp_d[k*PW +: PW] = v;
   endtask

   task automatic set_s_step(input int k);
      for (int i = 0; i < SR; i++)
         for (int p = 0; p < SP; p++) s_ref[(i*SP+p)*BD +: BD] = 8'(k + i);
   endtask

   task automatic set_s_exp(input int n);
      for (int j = 0; j < SC; j++)
         for (int p = 0; p < SP; p++) exp_s[(j*SP+p)*PW +: PW] = PW'(4*n - 12 + 4*j);
   endtask

   task automatic test_reset();
      #12;
      checks++; if (d_out !== '0) begin errs++; $display("FAIL reset_out: got %h want 0", d_out[PW-1:0]); end
      checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", d_ov); end
      checks++; if (d_rdy !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", d_rdy); end
      checks++; if (s_out !== '0 || s_ov !== 1'b0) begin errs++; $display("FAIL reset_skew_dut: out %h valid %b want 0", s_out, s_ov); end
      checks++; if (t_out !== '0 || t_rdy !== 1'b1) begin errs++; $display("FAIL reset_sat_dut: out %h ready %b want 0/1", t_out, t_rdy); end
      rst = 1'b1;
      tick();
   endtask

   // constant R=200, C=0: 14 silent steps, then 1600 on every further step
   task automatic test_fill();
      d_cur = '0; d_load = 1'b1; d_vld = 1'b0;
      tick();
      d_load = 1'b0;
      checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL fill_after_load: valid %b want 0", d_ov); end
      set_d_exp(11'd1600);
      for (int k = 1; k <= 18; k++) begin
         d_vld = 1'b1; set_d_ref(8'd200);
         tick();
         if (k < 15) begin
            checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL fill_early step %0d: valid %b want 0", k, d_ov); end
         end else begin
            checks++; if (d_ov !== 1'b1) begin errs++; $display("FAIL fill_pulse step %0d: valid %b want 1", k, d_ov); end
            checks++; if (d_out !== exp_d) begin errs++; $display("FAIL fill_data step %0d: lane0 got %0d want %0d", k, d_out[PW-1:0], exp_d[PW-1:0]); end
         end
      end
      d_vld = 1'b0; set_d_ref(8'd7);
      tick();
      checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL fill_idle: valid %b want 0", d_ov); end
      checks++; if (d_out !== exp_d) begin errs++; $display("FAIL fill_idle_hold: lane0 got %0d want %0d", d_out[PW-1:0], exp_d[PW-1:0]); end
   endtask

   // row i carries k+i on step k; column j settles at 4n-12+4j from step 6 on
   task automatic test_skew();
      s_cur = '0; s_load = 1'b1; s_vld = 1'b0;
      tick();
      s_load = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         s_vld = 1'b1; set_s_step(k);
         tick();
         if (k < 6) begin
            checks++; if (s_ov !== 1'b0) begin errs++; $display("FAIL skew_early step %0d: valid %b want 0", k, s_ov); end
         end else begin
            set_s_exp(k);
            checks++; if (s_ov !== 1'b1) begin errs++; $display("FAIL skew_pulse step %0d: valid %b want 1", k, s_ov); end
            checks++; if (s_out !== exp_s) begin errs++; $display("FAIL skew_data step %0d: got %h want %h", k, s_out, exp_s); end
         end
      end
      s_vld = 1'b0;
   endtask

   // same skew traffic with random idle cycles carrying junk data
   task automatic test_stall();
      int k;
      k = 0;
      s_load = 1'b1;
      tick();
      s_load = 1'b0;
      for (int cyc = 0; cyc < 300 && k <= 12; cyc++) begin
         s_vld = 1'($urandom_range(0, 1));
         if (s_vld) set_s_step(k);
         else s_ref = SR*SP*BD'($urandom);
         tick();
         if (s_vld) begin
            if (k < 6) begin
               checks++; if (s_ov !== 1'b0) begin errs++; $display("FAIL stall_early step %0d: valid %b want 0", k, s_ov); end
            end else begin
               set_s_exp(k);
               checks++; if (s_ov !== 1'b1 || s_out !== exp_s) begin errs++; $display("FAIL stall_data step %0d: valid %b got %h want %h", k, s_ov, s_out, exp_s); end
            end
            k++;
         end else begin
            checks++; if (s_ov !== 1'b0) begin errs++; $display("FAIL stall_idle at step %0d: valid %b want 0", k, s_ov); end
         end
      end
      s_vld = 1'b0;
      checks++; if (k <= 12) begin errs++; $display("FAIL stall_budget: reached step %0d want 13", k); end
   endtask

   // load collides with a beat on a full pipe: beat refused, refill with C=50
   task automatic test_collision();
      for (int k = 0; k < R*C; k++) d_cur[k*BD +: BD] = 8'd50;
      d_vld = 1'b1; set_d_ref(8'd200); d_load = 1'b1;
      #1;
      checks++; if (d_rdy !== 1'b0) begin errs++; $display("FAIL coll_ready: got %b want 0", d_rdy); end
      tick();
      d_load = 1'b0;
      set_d_exp(11'd1600);
      checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL coll_valid: got %b want 0", d_ov); end
      checks++; if (d_out !== exp_d) begin errs++; $display("FAIL coll_hold: lane0 got %0d want %0d", d_out[PW-1:0], exp_d[PW-1:0]); end
      set_d_exp(11'd1200);
      for (int k = 1; k <= 16; k++) begin
         d_vld = 1'b1;
         tick();
         if (k < 15) begin
            checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL coll_early step %0d: valid %b want 0", k, d_ov); end
         end else begin
            checks++; if (d_ov !== 1'b1 || d_out !== exp_d) begin errs++; $display("FAIL coll_data step %0d: valid %b lane0 %0d want 1/%0d", k, d_ov, d_out[PW-1:0], exp_d[PW-1:0]); end
         end
      end
      d_vld = 1'b0;
   endtask

   // reset between edges after 7 steps clears outputs and C; a full refill follows
   task automatic test_reset_mid();
      d_load = 1'b1;
      tick();
      d_load = 1'b0;
      for (int k = 0; k < 7; k++) begin
         d_vld = 1'b1;
         tick();
      end
      d_vld = 1'b0;
      #3 rst = 1'b0;
      #1;
      checks++; if (d_out !== '0) begin errs++; $display("FAIL rmid_out: lane0 got %0d want 0", d_out[PW-1:0]); end
      checks++; if (d_ov !== 1'b0 || d_rdy !== 1'b1) begin errs++; $display("FAIL rmid_flags: valid %b ready %b want 0/1", d_ov, d_rdy); end
      #2 rst = 1'b1;
      tick();
      set_d_exp(11'd1600);
      for (int k = 1; k <= 15; k++) begin
         d_vld = 1'b1; set_d_ref(8'd200);
         tick();
         if (k < 15) begin
            checks++; if (d_ov !== 1'b0) begin errs++; $display("FAIL rmid_early step %0d: valid %b want 0", k, d_ov); end
         end else begin
            checks++; if (d_ov !== 1'b1 || d_out !== exp_d) begin errs++; $display("FAIL rmid_data: valid %b lane0 %0d want 1/%0d", d_ov, d_out[PW-1:0], exp_d[PW-1:0]); end
         end
      end
      d_vld = 1'b0;
   endtask

   // |R-C|=255 in all 8 rows on a 9-bit PSAD: 511 saturated, 504 wrapped
   task automatic test_sat();
      logic [TW-1:0] want;
`ifdef AD_ARRAY_SAT_EN
      want = 9'd511;
`else
      want = 9'd504;
`endif
      for (int k = 0; k < C; k++) exp_t[k*TW +: TW] = want;
      t_cur = '0; t_load = 1'b1;
      tick();
      t_load = 1'b0;
      for (int k = 0; k < R*TP; k++) t_ref[k*BD +: BD] = 8'd255;
      for (int k = 1; k <= 15; k++) begin
         t_vld = 1'b1;
         tick();
         if (k == 14) begin
            checks++; if (t_ov !== 1'b0) begin errs++; $display("FAIL sat_early: valid %b want 0", t_ov); end
         end
      end
      t_vld = 1'b0;
      checks++; if (t_ov !== 1'b1 || t_out !== exp_t) begin errs++; $display("FAIL sat_data: valid %b got %h want %h", t_ov, t_out, exp_t); end
   endtask

   initial begin
      d_vld = 1'b0; d_load = 1'b0; d_ref = '0; d_cur = '0; exp_d = '0;
      s_vld = 1'b0; s_load = 1'b0; s_ref = '0; s_cur = '0; exp_s = '0;
      t_vld = 1'b0; t_load = 1'b0; t_ref = '0; t_cur = '0; exp_t = '0;
      test_reset();
      test_fill();
      test_skew();
      test_stall();
      test_collision();
      test_reset_mid();
      test_sat();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
